// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - byte/halfword/word load-store stage with wait-stated internal RAM
//
// Data-memory stage behind the ALU. It accepts one access at a time, runs it against
// an internal word-organised RAM after WAIT_STATES extra cycles, and answers with a
// single-cycle Done pulse. Illegal or misaligned accesses are answered on the next
// edge with MisalignErr and never touch the RAM.
//
// Ports:
//   CLK          clock, rising edge
//   RST          asynchronous active-low reset
//   Req          access request, sampled only while Busy=0
//   ALUResult    byte address; wraps modulo 4*DEPTH_WORDS
//   WriteData    store data (low bits used for SB/SH)
//   MemWrite     1 = store, 0 = load
//   Funct3       RISC-V width/sign code
//   ReadData     extended load result, held until the next load or error completion
//   Busy         access in progress
//   Done         one-cycle completion pulse
//   MisalignErr  valid with Done; the access was rejected
module load_store_unit #(
    parameter int DEPTH_WORDS = 256,
    parameter int WAIT_STATES = 2
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        Req,
    input  logic [31:0] ALUResult,
    input  logic [31:0] WriteData,
    input  logic        MemWrite,
    input  logic [2:0]  Funct3,
    output logic [31:0] ReadData,
    output logic        Busy,
    output logic        Done,
    output logic        MisalignErr
);

    localparam int AW = $clog2(DEPTH_WORDS);
    localparam int CW = (WAIT_STATES > 0) ? $clog2(WAIT_STATES + 1) : 1;

    typedef enum logic {
        S_IDLE,
        S_WAIT
    } state_t;

    state_t        state_q;
    logic [CW-1:0] cnt_q;
    logic [AW+1:0] addr_q;
    logic [31:0]   wdata_q;
    logic          we_q;
    logic [2:0]    f3_q;
    logic [31:0]   rdata_q;
    logic          busy_q;
    logic          done_q;
    logic          err_q;

    logic [31:0]   mem [DEPTH_WORDS];

    logic          illegal;
    logic          complete;
    logic          mem_we;
    logic [AW-1:0] widx;
    logic [1:0]    lane;
    logic [3:0]    byte_en;
    logic [31:0]   wdata_lane;
    logic [31:0]   word_rd;
    logic [7:0]    byte_sel;
    logic [15:0]   half_sel;
    logic [31:0]   load_val;

    // Address bits above the RAM span are ignored so addresses wrap.
    logic unused_addr_bits;
    assign unused_addr_bits = ^ALUResult[31:AW+2];

    assign ReadData    = rdata_q;
    assign Busy        = busy_q;
    assign Done        = done_q;
    assign MisalignErr = err_q;

    assign widx     = addr_q[AW+1:2];
    assign lane     = addr_q[1:0];
    assign complete = (state_q == S_WAIT) && (cnt_q == '0);
    assign mem_we   = complete && we_q;
    assign word_rd  = mem[widx];

    // Legality is judged on the live inputs because it is only consulted at acceptance.
    always_comb begin
        illegal = 1'b0;
        if (MemWrite) begin
            illegal = !(Funct3 inside {3'b000, 3'b001, 3'b010});
        end else begin
            illegal = !(Funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
        end
        if ((Funct3[1:0] == 2'b01) && ALUResult[0]) begin
            illegal = 1'b1;
        end
        if ((Funct3[1:0] == 2'b10) && (ALUResult[1:0] != 2'b00)) begin
            illegal = 1'b1;
        end
    end

    // Store data is replicated across lanes; the byte enables pick the lanes written.
    always_comb begin
        byte_en    = 4'b1111;
        wdata_lane = wdata_q;
        case (f3_q[1:0])
            2'b00: begin
                byte_en    = 4'b0001 << lane;
                wdata_lane = {4{wdata_q[7:0]}};
            end
            2'b01: begin
                byte_en    = lane[1] ? 4'b1100 : 4'b0011;
                wdata_lane = {2{wdata_q[15:0]}};
            end
            default: begin
                byte_en    = 4'b1111;
                wdata_lane = wdata_q;
            end
        endcase
    end

    always_comb begin
        byte_sel = word_rd[{lane, 3'b000} +: 8];
        half_sel = lane[1] ? word_rd[31:16] : word_rd[15:0];
        case (f3_q)
            3'b000:  load_val = {{24{byte_sel[7]}}, byte_sel};
            3'b001:  load_val = {{16{half_sel[15]}}, half_sel};
            3'b100:  load_val = {24'h0, byte_sel};
            3'b101:  load_val = {16'h0, half_sel};
            default: load_val = word_rd;
        endcase
    end

    // RAM has no reset; an asynchronous reset forces state_q to IDLE, which kills mem_we.
    always_ff @(posedge CLK) begin
        if (mem_we) begin
            for (int b = 0; b < 4; b++) begin
                if (byte_en[b]) begin
                    mem[widx][8*b +: 8] <= wdata_lane[8*b +: 8];
                end
            end
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            we_q    <= 1'b0;
            f3_q    <= 3'b000;
            rdata_q <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            err_q  <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (Req) begin
                        if (illegal) begin
                            // Rejected in place: no wait states, Busy never rises.
                            done_q  <= 1'b1;
                            err_q   <= 1'b1;
                            rdata_q <= '0;
                        end else begin
                            addr_q  <= ALUResult[AW+1:0];
                            wdata_q <= WriteData;
                            we_q    <= MemWrite;
                            f3_q    <= Funct3;
                            cnt_q   <= CW'(WAIT_STATES);
                            busy_q  <= 1'b1;
                            state_q <= S_WAIT;
                        end
                    end
                end
                S_WAIT: begin
                    if (cnt_q == '0) begin
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        if (!we_q) begin
                            rdata_q <= load_val;
                        end
                    end else begin
                        cnt_q <= cnt_q - CW'(1);
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// tb/tb_load_store_unit.sv - directed self-checking bench for load_store_unit
module tb_load_store_unit;

    logic        CLK;
    logic        RST;

    logic        Req;
    logic [31:0] ALUResult;
    logic [31:0] WriteData;
    logic        MemWrite;
    logic [2:0]  Funct3;
    logic [31:0] ReadData;
    logic        Busy;
    logic        Done;
    logic        MisalignErr;

    logic        req0;
    logic [31:0] addr0;
    logic [31:0] wd0;
    logic        we0;
    logic [2:0]  f30;
    logic [31:0] rd0;
    logic        busy0;
    logic        done0;
    logic        err0;

    int          n_checks;
    int          n_fail;
    logic [31:0] exp_last;

    load_store_unit #(.DEPTH_WORDS(256), .WAIT_STATES(2)) u_dut (
        .CLK(CLK), .RST(RST), .Req(Req), .ALUResult(ALUResult), .WriteData(WriteData),
        .MemWrite(MemWrite), .Funct3(Funct3), .ReadData(ReadData), .Busy(Busy),
        .Done(Done), .MisalignErr(MisalignErr)
    );

    load_store_unit #(.DEPTH_WORDS(256), .WAIT_STATES(0)) u_dut0 (
        .CLK(CLK), .RST(RST), .Req(req0), .ALUResult(addr0), .WriteData(wd0),
        .MemWrite(we0), .Funct3(f30), .ReadData(rd0), .Busy(busy0),
        .Done(done0), .MisalignErr(err0)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s act=%08h exp=%08h", tag, act, exp);
        end
    endtask

    // One access on the WAIT_STATES=2 instance. poke re-raises Req during Busy to
    // prove it is ignored. Inputs are scrambled right after acceptance to prove capture.
    task automatic access(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                          input logic [31:0] wd, input logic exp_err,
                          input logic [31:0] exp_rd, input logic poke, input string tag);
        int busy_n;
        int n;
        int extra;
        @(negedge CLK);
        Req = 1'b1; MemWrite = we; Funct3 = f3; ALUResult = addr; WriteData = wd;
        @(posedge CLK); #1;
        Req = 1'b0; MemWrite = ~we; Funct3 = 3'b010; ALUResult = 32'hFFFF_FFFC; WriteData = ~wd;
        if (exp_err) begin
            exp_last = 32'h0;
            chk({tag, "_done"}, {31'h0, Done}, 32'h1);
            chk({tag, "_err"}, {31'h0, MisalignErr}, 32'h1);
            chk({tag, "_busy"}, {31'h0, Busy}, 32'h0);
            chk({tag, "_rd"}, ReadData, 32'h0);
        end else begin
            busy_n = 0;
            n = 0;
            while (!Done && n < 50) begin
                busy_n += int'(Busy);
                Req = poke && (n == 0);
                @(posedge CLK); #1;
                n++;
            end
            Req = 1'b0;
            if (!we) exp_last = exp_rd;
            chk({tag, "_done"}, {31'h0, Done}, 32'h1);
            chk({tag, "_err"}, {31'h0, MisalignErr}, 32'h0);
            chk({tag, "_busycyc"}, busy_n, 32'd3);
            chk({tag, "_rd"}, ReadData, exp_last);
        end
        extra = 0;
        for (int i = 0; i < 4; i++) begin
            @(posedge CLK); #1;
            extra += int'(Done);
        end
        chk({tag, "_nodone"}, extra, 32'd0);
    endtask

    logic        b_we   [7];
    logic [2:0]  b_f3   [7];
    logic [31:0] b_addr [7];
    logic [31:0] b_wd   [7];
    logic [31:0] b_exp  [7];

    initial begin
        int n;
        n_checks = 0; n_fail = 0; exp_last = 32'h0;
        RST = 1'b0;
        Req = 1'b0; ALUResult = 32'h0; WriteData = 32'h0; MemWrite = 1'b0; Funct3 = 3'b000;
        req0 = 1'b0; addr0 = 32'h0; wd0 = 32'h0; we0 = 1'b0; f30 = 3'b000;

        repeat (3) @(posedge CLK);
        #1;
        chk("rst_busy", {31'h0, Busy}, 32'h0);
        chk("rst_done", {31'h0, Done}, 32'h0);
        chk("rst_err", {31'h0, MisalignErr}, 32'h0);
        chk("rst_rd", ReadData, 32'h0);
        @(negedge CLK);
        RST = 1'b1;

        access(1'b1, 3'b010, 32'h10, 32'hDEADBEEF, 1'b0, 32'h0, 1'b0, "sw10");
        access(1'b0, 3'b010, 32'h10, 32'h0, 1'b0, 32'hDEADBEEF, 1'b1, "lw10_poke");

        access(1'b0, 3'b000, 32'h13, 32'h0, 1'b0, 32'hFFFFFFDE, 1'b0, "lb13");
        access(1'b0, 3'b100, 32'h13, 32'h0, 1'b0, 32'h000000DE, 1'b0, "lbu13");
        access(1'b0, 3'b001, 32'h12, 32'h0, 1'b0, 32'hFFFFDEAD, 1'b0, "lh12");
        access(1'b0, 3'b101, 32'h10, 32'h0, 1'b0, 32'h0000BEEF, 1'b0, "lhu10");
        access(1'b0, 3'b000, 32'h10, 32'h0, 1'b0, 32'hFFFFFFEF, 1'b0, "lb10");

        access(1'b1, 3'b000, 32'h11, 32'h123456AA, 1'b0, 32'h0, 1'b0, "sb11");
        access(1'b0, 3'b010, 32'h10, 32'h0, 1'b0, 32'hDEADAAEF, 1'b0, "lw_after_sb");
        access(1'b1, 3'b001, 32'h12, 32'h00007777, 1'b0, 32'h0, 1'b0, "sh12");
        access(1'b0, 3'b010, 32'h10, 32'h0, 1'b0, 32'h7777AAEF, 1'b0, "lw_after_sh");

        access(1'b0, 3'b010, 32'h12, 32'h0, 1'b1, 32'h0, 1'b0, "lw12_mis");
        access(1'b1, 3'b001, 32'h13, 32'hFFFFFFFF, 1'b1, 32'h0, 1'b0, "sh13_mis");
        access(1'b0, 3'b010, 32'h10, 32'h0, 1'b0, 32'h7777AAEF, 1'b0, "lw_after_mis");
        access(1'b0, 3'b011, 32'h10, 32'h0, 1'b1, 32'h0, 1'b0, "ld_f3_011");
        access(1'b1, 3'b100, 32'h10, 32'h0, 1'b1, 32'h0, 1'b0, "st_f3_100");

        access(1'b1, 3'b010, 32'h20, 32'h11111111, 1'b0, 32'h0, 1'b0, "sw20");
        access(1'b0, 3'b010, 32'h20, 32'h0, 1'b0, 32'h11111111, 1'b0, "lw20");

        @(negedge CLK);
        Req = 1'b1; MemWrite = 1'b1; Funct3 = 3'b010; ALUResult = 32'h20; WriteData = 32'h22222222;
        @(posedge CLK); #1;
        Req = 1'b0;
        chk("abort_busy_before", {31'h0, Busy}, 32'h1);
        @(posedge CLK); #2;
        RST = 1'b0;
        #1;
        chk("abort_busy_async", {31'h0, Busy}, 32'h0);
        chk("abort_rd_async", ReadData, 32'h0);
        @(negedge CLK);
        RST = 1'b1;
        exp_last = 32'h0;
        n = 0;
        for (int i = 0; i < 6; i++) begin
            @(posedge CLK); #1;
            n += int'(Done);
        end
        chk("abort_nodone", n, 32'd0);
        access(1'b0, 3'b010, 32'h20, 32'h0, 1'b0, 32'h11111111, 1'b0, "lw20_after_abort");

        access(1'b1, 3'b010, 32'h400, 32'h00000055, 1'b0, 32'h0, 1'b0, "sw400");
        access(1'b0, 3'b010, 32'h000, 32'h0, 1'b0, 32'h00000055, 1'b0, "lw0_wrap");

        b_we[0] = 1'b1; b_f3[0] = 3'b010; b_addr[0] = 32'h40; b_wd[0] = 32'hA5A50001; b_exp[0] = 32'h0;
        b_we[1] = 1'b0; b_f3[1] = 3'b010; b_addr[1] = 32'h40; b_wd[1] = 32'h0;        b_exp[1] = 32'hA5A50001;
        b_we[2] = 1'b1; b_f3[2] = 3'b010; b_addr[2] = 32'h44; b_wd[2] = 32'h0BADF00D; b_exp[2] = 32'h0;
        b_we[3] = 1'b0; b_f3[3] = 3'b010; b_addr[3] = 32'h44; b_wd[3] = 32'h0;        b_exp[3] = 32'h0BADF00D;
        b_we[4] = 1'b1; b_f3[4] = 3'b010; b_addr[4] = 32'h40; b_wd[4] = 32'h12345678; b_exp[4] = 32'h0;
        b_we[5] = 1'b0; b_f3[5] = 3'b010; b_addr[5] = 32'h40; b_wd[5] = 32'h0;        b_exp[5] = 32'h12345678;
        b_we[6] = 1'b0; b_f3[6] = 3'b001; b_addr[6] = 32'h42; b_wd[6] = 32'h0;        b_exp[6] = 32'h00001234;

        @(negedge CLK);
        req0 = 1'b1; we0 = b_we[0]; f30 = b_f3[0]; addr0 = b_addr[0]; wd0 = b_wd[0];
        for (int i = 0; i < 7; i++) begin
            @(posedge CLK); #1;
            chk($sformatf("b2b%0d_accept", i), {31'h0, busy0}, 32'h1);
            if (i < 6) begin
                we0 = b_we[i+1]; f30 = b_f3[i+1]; addr0 = b_addr[i+1]; wd0 = b_wd[i+1];
            end else begin
                req0 = 1'b0;
            end
            @(posedge CLK); #1;
            chk($sformatf("b2b%0d_done", i), {31'h0, done0}, 32'h1);
            chk($sformatf("b2b%0d_err", i), {31'h0, err0}, 32'h0);
            if (!b_we[i]) begin
                chk($sformatf("b2b%0d_rd", i), rd0, b_exp[i]);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
